led_activity_stretcher: RTL and testbench
=========================================

Name: led_activity_stretcher

Overview:
Sits directly downstream of the Propeller core's cog LED outputs and drives the board's active-low user LEDs.
Cog activity pulses can be as short as one clock, so each channel is resynchronised, then pulse-stretched to a visible minimum on-time.
All channels are gated by a shared 8-bit PWM dimmer.
Replaces the plain inversion of cog_led in the board top-levels; runs on the fixed clock_160 domain.

Parameters:
N, 8, number of LED channels
HOLD_CYCLES, 8000000, extra on-cycles after input falls (50 ms at 160 MHz); 0 = no stretch
CNT_W, $clog2(HOLD_CYCLES+1), hold counter width (derived, not overridden)
PWM_DIV, 625, clock prescale per PWM step (160 MHz/625/256 ≈ 1 kHz PWM); must be >= 1

Ports:
clock  input  1  fixed-frequency clock (clock_160)
resn  input  1  asynchronous active-low reset
led_in  input  N  cog LED activity, active high, asynchronous to clock (clk_cog domain)
brightness  input  8  duty: 0 = off, 255 = fully on, k = k/256 on-time
led_n  output  N  LED drive, active low, registered
active  output  N  stretched activity before PWM gating, active high, registered

Behaviour:
- Reset: the clock and reset are already decided. One clock, `clock`. Reset is asynchronous and active-low, `resn`. All flops clear immediately when resn = 0; no clock is needed.
- Reset values: led_n = all 1 (LEDs off), active = 0, sync flops = 0, hold counters = 0, prescaler = 0, pwm_cnt = 0, brightness_q = 8'hFF.
- Cycle n means the state after clock edge n.
- Sync:
  - 2-flop synchroniser per bit: sync1 <= led_in; sync2 <= sync1.
  - led_in high before edge 1 gives sync2 = 1 at cycle 2.
- Hold counter, per channel:
  - if sync2 = 1: cnt <= HOLD_CYCLES;
  - else if cnt != 0: cnt <= cnt - 1;
  - else hold.
  - Re-trigger while counting reloads the counter to HOLD_CYCLES; it never accumulates.
- Stretch: stretched = sync2 | (cnt != 0); active <= stretched.
- Prescaler:
  - counts 0..PWM_DIV-1 and wraps to 0;
  - tick = (prescaler == PWM_DIV-1);
  - PWM_DIV = 1 means tick every cycle.
- PWM counter:
  - 8-bit pwm_cnt increments on tick; 255 wraps to 0.
  - On the tick where pwm_cnt == 255: brightness_q <= brightness.
  - brightness changes therefore take effect only at a period boundary.
- PWM gate: pwm_on = (brightness_q == 255) | (pwm_cnt < brightness_q).
  - brightness_q = 0 means never on.
  - brightness_q = 255 means always on (no 1/256 gap).
- Output: led_n <= ~(stretched & {N{pwm_on}}), registered.
- Latency: led_in rising to led_n falling is 3 edges (brightness 255).
- Single-cycle input pulse gives led_n low for exactly 1 + HOLD_CYCLES cycles (cycles 3 .. 3+HOLD_CYCLES).
- Input held high gives led_n low until 3 + HOLD_CYCLES cycles after the last cycle led_in was sampled high.
- HOLD_CYCLES = 0: pure 3-cycle delayed pass-through; the counter logic may be optimised out.
- Simultaneous reload and decrement: reload wins.
- Channels are fully independent except for the shared PWM gate.
- resn asserted mid-hold or mid-PWM period: all state clears immediately. After release there is no residual stretch, and the PWM period restarts at pwm_cnt = 0 with brightness_q = 255 until the first wrap.

Test Plan:
(HOLD_CYCLES=10, PWM_DIV=1 unless stated)
1. Reset: resn = 0 with led_in = 8'hFF → led_n = 8'hFF immediately, without a clock edge. Release with led_in = 0 → led_n stays 8'hFF and active = 0.
2. Single pulse: brightness = 255; led_in[0] = 1 for one cycle before edge 1 → led_n[0] = 0 for cycles 3..13 (11 cycles) and 1 at cycle 14. Other bits stay 1.
3. Retrigger: led_in[2] pulsed before edges 1 and 6 → led_n[2] low continuously from cycle 3 through cycle 18. No gap, no extension beyond the reload.
4. PWM: led_in[3] held high, brightness = 64, after the first period wrap → led_n[3] low on exactly 64 of every 256 cycles, while active[3] stays 1. brightness = 0 → led_n[3] always 1. brightness = 255 → always 0.
5. Brightness update: change brightness 64→192 mid-period → duty stays 64 until the pwm_cnt 255→0 wrap, then becomes 192/256. Repeat with PWM_DIV=4 → each PWM step lasts 4 cycles.
6. Reset mid-operation: resn pulsed low at cycle 6 of a 10-cycle hold → led_n = 8'hFF at once. After release with led_in = 0 → no LED comes on and active = 0.

Source files
------------

// File: rtl/led_activity_stretcher.sv
// Per-channel LED activity stretcher: 2-flop resync, retriggerable hold timer,
// shared 8-bit PWM dimmer, active-low registered LED drive.
module led_activity_stretcher #(
  parameter int N           = 8,
  parameter int HOLD_CYCLES = 8000000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1),
  parameter int PWM_DIV     = 625
) (
  input  logic         clock,
  input  logic         resn,
  input  logic [N-1:0] led_in,
  input  logic [7:0]   brightness,
  output logic [N-1:0] led_n,
  output logic [N-1:0] active
);

  // Widths clamped to 1 so HOLD_CYCLES = 0 / PWM_DIV = 1 still elaborate.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam int PW = (PWM_DIV < 2) ? 1 : $clog2(PWM_DIV);

  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [N-1:0]  stretched;
  logic [PW-1:0] prescaler;
  logic [7:0]    pwm_cnt;
  logic [7:0]    brightness_q;
  logic          tick;
  logic          pwm_on;

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= led_in;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge resn) begin
      if (!resn) begin
        cnt <= '0;
      end else if (sync2[g]) begin
        cnt <= CW'(HOLD_CYCLES);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end

    assign stretched[g] = sync2[g] | (cnt != '0);
  end

  assign tick   = (prescaler == PW'(PWM_DIV - 1));
  assign pwm_on = (brightness_q == 8'hFF) | (pwm_cnt < brightness_q);

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      prescaler    <= '0;
      pwm_cnt      <= '0;
      brightness_q <= 8'hFF;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
        // Duty only changes at a period boundary to avoid partial-period glitches.
        if (pwm_cnt == 8'hFF) begin
          brightness_q <= brightness;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resn) begin
    if (!resn) begin
      active <= '0;
      led_n  <= '1;
    end else begin
      active <= stretched;
      led_n  <= ~(stretched & {N{pwm_on}});
    end
  end

endmodule

// File: tb/tb_led_activity_stretcher.sv
// Bench for led_activity_stretcher: directed table, hand sequences and random
// stimulus against an edge-counting reference model, with PWM_DIV = 1 and 4.
module tb_led_activity_stretcher;
  localparam int N = 8;
  localparam int H = 10;

  logic       clock = 1'b0;
  logic       resn = 1'b1;
  logic [7:0] led_in = '0;
  logic [7:0] brightness = 8'hFF;
  logic [7:0] led_n0, active0, led_n1, active1;

  always #5 clock = ~clock;

  led_activity_stretcher #(.N(N), .HOLD_CYCLES(H), .PWM_DIV(1)) u0 (
    .clock(clock), .resn(resn), .led_in(led_in), .brightness(brightness),
    .led_n(led_n0), .active(active0));

  led_activity_stretcher #(.N(N), .HOLD_CYCLES(H), .PWM_DIV(4)) u1 (
    .clock(clock), .resn(resn), .led_in(led_in), .brightness(brightness),
    .led_n(led_n1), .active(active1));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: edges since reset, last edge each channel was seen high
  // after the 2-edge resync delay, and PWM position derived from edge count.
  int         e;
  int         last[N];
  bit         valid[N];
  logic [7:0] p1, p2;
  int         div[2] = '{1, 4};
  int         pcnt[2];
  logic [7:0] bq[2];
  logic [7:0] exp_active;
  logic [7:0] exp_led[2];

  function automatic bit pwm_on(int j);
    return (bq[j] == 8'hFF) || (pcnt[j] < int'(bq[j]));
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0; p1 = '0; p2 = '0;
    for (int i = 0; i < N; i++) begin valid[i] = 1'b0; last[i] = 0; end
    for (int j = 0; j < 2; j++) begin pcnt[j] = 0; bq[j] = 8'hFF; exp_led[j] = 8'hFF; end
    exp_active = '0;
  endtask

  // Called at a negedge; asserts reset, checks outputs clear without an edge.
  task automatic do_reset(int low_cycles, logic [7:0] rel_in);
    resn = 1'b0;
    model_reset();
    #1;
    check("reset led_n div1", led_n0, 8'hFF);
    check("reset active div1", active0, 8'h00);
    check("reset led_n div4", led_n1, 8'hFF);
    check("reset active div4", active1, 8'h00);
    repeat (low_cycles) @(negedge clock);
    led_in = rel_in;
    resn = 1'b1;
  endtask

  // One clock edge: advance model, then compare both DUTs at the negedge.
  task automatic tick();
    logic [7:0] in_now, br_now;
    bit on_prev[2];
    in_now = led_in;
    br_now = brightness;
    for (int j = 0; j < 2; j++) on_prev[j] = pwm_on(j);
    @(posedge clock);
    e++;
    for (int ch = 0; ch < N; ch++) begin
      if (p2[ch]) begin last[ch] = e - 2; valid[ch] = 1'b1; end
    end
    p2 = p1;
    p1 = in_now;
    for (int ch = 0; ch < N; ch++) exp_active[ch] = valid[ch] && (e - last[ch] <= H + 2);
    for (int j = 0; j < 2; j++) begin
      exp_led[j] = ~(exp_active & {8{on_prev[j]}});
      if (e % div[j] == 0) begin
        pcnt[j] = (e / div[j]) % 256;
        if (pcnt[j] == 0) bq[j] = br_now;
      end
    end
    @(negedge clock);
    check("model led_n div1", led_n0, exp_led[0]);
    check("model active div1", active0, exp_active);
    check("model led_n div4", led_n1, exp_led[1]);
    check("model active div4", active1, exp_active);
  endtask

  task automatic count_low(int cycles, output int c0, output int c1);
    c0 = 0; c1 = 0;
    repeat (cycles) begin
      tick();
      if (!led_n0[3]) c0++;
      if (!led_n1[3]) c1++;
    end
  endtask

  typedef struct {
    logic [7:0] in;
    logic [7:0] br;
    logic [7:0] exp_n;
    logic [7:0] exp_act;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int c0, c1;
    // Entry c-1 holds led_in before edge c and the outputs expected at cycle c.
    for (int c = 1; c <= 20; c++) begin
      tbl[c-1].in    = {5'b0, (c == 1 || c == 6), 1'b0, (c == 1)};
      tbl[c-1].br    = 8'hFF;
      tbl[c-1].exp_n = {5'b11111, !(c >= 3 && c <= 18), 1'b1, !(c >= 3 && c <= 13)};
      tbl[c-1].exp_act = ~tbl[c-1].exp_n;
    end

    // Reset with all inputs high, release with inputs low.
    led_in = 8'hFF;
    #2;
    do_reset(2, 8'h00);
    repeat (3) tick();
    check("post-reset led_n", led_n0, 8'hFF);
    check("post-reset active", active0, 8'h00);

    // Single pulse on bit 0 and retrigger on bit 2.
    do_reset(2, 8'h00);
    for (int i = 0; i < 20; i++) begin
      led_in = tbl[i].in;
      brightness = tbl[i].br;
      tick();
      check("table led_n div1", led_n0, tbl[i].exp_n);
      check("table led_n div4", led_n1, tbl[i].exp_n);
      check("table active", active0, tbl[i].exp_act);
    end

    // Reset in the middle of a hold.
    do_reset(2, 8'h00);
    led_in = 8'h01;
    tick();
    led_in = 8'h00;
    repeat (5) tick();
    check("mid-hold active before reset", active0, 8'h01);
    do_reset(2, 8'h00);
    repeat (15) tick();
    check("no residual stretch", led_n0, 8'hFF);

    // PWM duty with channel 3 held high.
    do_reset(2, 8'h08);
    brightness = 8'd64;
    repeat (1100) tick();
    count_low(1024, c0, c1);
    check_int("duty 64 div1", c0, 256);
    check_int("duty 64 div4", c1, 256);
    check("active held during PWM", active0, 8'h08);
    brightness = 8'd0;
    repeat (1100) tick();
    count_low(1024, c0, c1);
    check_int("duty 0 div1", c0, 0);
    check_int("duty 0 div4", c1, 0);
    brightness = 8'd255;
    repeat (1100) tick();
    count_low(1024, c0, c1);
    check_int("duty 255 div1", c0, 1024);
    check_int("duty 255 div4", c1, 1024);

    // Brightness change mid-period waits for the wrap.
    do_reset(2, 8'h08);
    brightness = 8'd64;
    repeat (300) tick();
    brightness = 8'd192;
    count_low(212, c0, c1);
    check_int("old duty until wrap", c0, 20);
    count_low(256, c0, c1);
    check_int("new duty after wrap", c0, 192);
    repeat (332) tick();
    count_low(1024, c0, c1);
    check_int("duty 192 div1", c0, 768);
    check_int("duty 192 div4", c1, 768);

    // Random activity, brightness changes and occasional resets.
    do_reset(2, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      led_in = 8'($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0: brightness = 8'd0;
          1: brightness = 8'd255;
          default: brightness = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 999) == 0) do_reset(1, 8'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
